// File: rtl/fp24_pkg.sv
// FP24 shared types: 1 sign, 7 exponent (bias 63), 16 fraction.
// Used by the FP24 divider and multiplier; holds divider FSM states.
package fp24_pkg;

  localparam int FP_EXP_W  = 7;
  localparam int FP_FRAC_W = 16;
  localparam int FP_BIAS   = 63;

  localparam logic [22:0] FP_MAX_MAG = 23'h7F_FFFF;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp24_t;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } div_state_e;

endpackage

// File: rtl/fp_div_if.sv
// Operand/result handshake bundle for the FP24 divider.
// slave: a_i, b_i, valid_i, ready_i in; ready_o, result_o, dz_o, valid_o out.
interface fp_div_if;

  logic [23:0] a_i;
  logic [23:0] b_i;
  logic        valid_i;
  logic        ready_o;
  logic [23:0] result_o;
  logic        dz_o;
  logic        valid_o;
  logic        ready_i;

  modport slave (
    input  a_i, b_i, valid_i, ready_i,
    output ready_o, result_o, dz_o, valid_o
  );

  modport master (
    output a_i, b_i, valid_i, ready_i,
    input  ready_o, result_o, dz_o, valid_o
  );

endinterface

// File: rtl/fp_div_norm.sv
// Combinational normalise/round/range check of the raw quotient.
// In: q, rem, e, sign. Out: res. FP_DIV_ROUND_EN selects RNE rounding.
module fp_div_norm
  import fp24_pkg::*;
(
  input  logic [18:0]       q,
  input  logic [17:0]       rem,
  input  logic signed [8:0] e,
  input  logic              sign,
  output fp24_t             res
);

  logic [15:0]       frac;
  logic              guard;
  logic              sticky;
  logic signed [8:0] ex;

`ifdef FP_DIV_ROUND_EN
  logic [16:0] sum;
`else
  logic unused_bits;
  assign unused_bits = guard ^ sticky;
`endif

  always_comb begin
    frac   = q[16:1];
    guard  = q[0];
    sticky = |rem;
    ex     = e - 9'sd1;
    if (q[18]) begin
      frac   = q[17:2];
      guard  = q[1];
      sticky = q[0] | (|rem);
      ex     = e;
    end
`ifdef FP_DIV_ROUND_EN
    sum = {1'b0, frac}
        + 17'(guard & (sticky | frac[0]));
    frac = sum[15:0];
    if (sum[16]) begin
      frac = '0;
      ex   = ex + 9'sd1;
    end
`endif
    res = '{sign: sign,
            exp:  ex[6:0],
            frac: frac};
    if (ex > 9'sd127) begin
      res = {sign, FP_MAX_MAG};
    end else if (ex <= 9'sd0) begin
      res = {sign, 23'b0};
    end
  end

endmodule

// File: rtl/fp_div.sv
// Iterative restoring FP24 divider, result = a / b, one op in flight.
// Ports: clk, rst_n (sync, low), io (fp_div_if.slave). Macro: FP_DIV_ROUND_EN.
module fp_div
  import fp24_pkg::*;
#(
  parameter int ITER = 19
) (
  input  logic     clk,
  input  logic     rst_n,
  fp_div_if.slave  io
);

  div_state_e state;
  div_state_e nxt;

  logic [4:0]        cnt;
  logic [ITER-1:0]   q;
  logic [17:0]       rem;
  logic [17:0]       mb;
  logic [17:0]       diff;
  logic              ge;
  logic signed [8:0] e;
  logic              sgn;
  fp24_t             res;
  logic              dz;
  fp24_t             norm_res;

  fp24_t a;
  fp24_t b;
  logic  a_zero;
  logic  b_zero;
  logic  last;

  assign a      = io.a_i;
  assign b      = io.b_i;
  assign a_zero = (a.exp == '0);
  assign b_zero = (b.exp == '0);
  assign last   = (cnt == 5'(ITER - 1));

  assign ge   = (rem >= mb);
  assign diff = ge ? rem - mb : rem;

  assign io.ready_o  = (state == IDLE);
  assign io.valid_o  = (state == DONE);
  assign io.result_o = res;
  assign io.dz_o     = dz;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (io.valid_i)
          nxt = (a_zero | b_zero) ? DONE : DIV;
      end
      DIV:  if (last) nxt = NORM;
      NORM: nxt = DONE;
      DONE: if (io.ready_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= '0;
      rem <= '0;
      mb  <= '0;
      e   <= '0;
      sgn <= 1'b0;
      res <= '0;
      dz  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.valid_i) begin
            sgn <= a.sign ^ b.sign;
            e   <= $signed({2'b00, a.exp})
                 - $signed({2'b00, b.exp})
                 + 9'sd63;
            rem <= {2'b01, a.frac};
            mb  <= {2'b01, b.frac};
            cnt <= '0;
            q   <= '0;
            if (b_zero) begin
              res <= {a.sign ^ b.sign, FP_MAX_MAG};
              dz  <= 1'b1;
            end else if (a_zero) begin
              res <= {a.sign ^ b.sign, 23'b0};
              dz  <= 1'b0;
            end
          end
        end
        DIV: begin
          q   <= {q[ITER-2:0], ge};
          rem <= diff << 1;
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          res <= norm_res;
          dz  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fp_div_norm u_norm (
    .q    (q),
    .rem  (rem),
    .e    (e),
    .sign (sgn),
    .res  (norm_res)
  );

endmodule

// File: tb/tb_fp_div.sv
// Directed scoreboard bench for fp_div.
// Covers specials, range, latency, back-pressure, busy and reset.
module tb_fp_div;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fp_div_if bus ();

  fp_div #(.ITER(19)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [24:0] sb [$];

`ifdef FP_DIV_ROUND_EN
  localparam logic [23:0] FIFTH = 24'h3C999A;
`else
  localparam logic [23:0] FIFTH = 24'h3C9999;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h",
             tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [23:0] a,
                        input logic [23:0] b,
                        input bit push,
                        input logic [23:0] r,
                        input logic dz);
    int n = 0;
    while (!bus.ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(bus.ready_o), 1);
    bus.a_i = a;
    bus.b_i = b;
    bus.valid_i = 1'b1;
    if (push) sb.push_back({dz, r});
    tick();
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag,
                            input int lat,
                            input int start);
    int n = start;
    while (!bus.valid_o && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic take(input string tag);
    logic [24:0] ex;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
    ex = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, "_res"}, 32'(bus.result_o), 32'(ex[23:0]));
    chk({tag, "_dz"}, 32'(bus.dz_o), 32'(ex[24]));
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk({tag, "_idle"}, 32'(bus.ready_o), 1);
  endtask

  task automatic op(input string tag,
                    input logic [23:0] a,
                    input logic [23:0] b,
                    input logic [23:0] r,
                    input logic dz,
                    input int lat);
    accept(a, b, 1'b1, r, dz);
    wait_valid(tag, lat, 1);
    take(tag);
  endtask

  initial begin
    logic [23:0] held;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.ready_o), 1);
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_res", 32'(bus.result_o), 0);
    chk("rst_dz", 32'(bus.dz_o), 0);
    rst_n = 1'b1;
    tick();

    op("six_3", 24'h418000, 24'h408000, 24'h400000, 0, 21);
    op("one_5", 24'h3F0000, 24'h414000, FIFTH, 0, 21);
    op("neg6_3", 24'hC18000, 24'h408000, 24'hC00000, 0, 21);
    op("ovf", 24'h7F0000, 24'h3E0000, 24'h7FFFFF, 0, 21);
    op("unf", 24'h010000, 24'h7F0000, 24'h000000, 0, 21);
    op("div0", 24'h3F0000, 24'h000000, 24'h7FFFFF, 1, 1);
    op("zero0", 24'h000000, 24'h000000, 24'h7FFFFF, 1, 1);
    op("neg0", 24'hBF0000, 24'h000000, 24'hFFFFFF, 1, 1);
    op("zero_a", 24'h000000, 24'h408000, 24'h000000, 0, 1);
    op("half", 24'h3F0000, 24'h400000, 24'h3E0000, 0, 21);

    accept(24'h418000, 24'h408000, 1'b1, 24'h400000, 0);
    wait_valid("bp", 21, 1);
    held = bus.result_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", 32'(bus.result_o), 32'(held));
      chk("bp_ready", 32'(bus.ready_o), 0);
      chk("bp_valid", 32'(bus.valid_o), 1);
    end
    take("bp");

    accept(24'h418000, 24'h408000, 1'b1, 24'h400000, 0);
    repeat (4) tick();
    bus.a_i = 24'h3F0000;
    bus.b_i = 24'h000000;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    wait_valid("busy", 21, 6);
    take("busy");
    chk("busy_novalid", 32'(bus.valid_o), 0);

    accept(24'h418000, 24'h408000, 1'b0, 24'h0, 0);
    repeat (9) tick();
    chk("mid_busy", 32'(bus.ready_o), 0);
    rst_n = 1'b0;
    tick();
    chk("mid_ready", 32'(bus.ready_o), 1);
    chk("mid_valid", 32'(bus.valid_o), 0);
    chk("mid_res", 32'(bus.result_o), 0);
    rst_n = 1'b1;
    repeat (15) tick();
    chk("mid_gone", 32'(bus.valid_o), 0);
    op("post_rst", 24'h418000, 24'h408000, 24'h400000, 0, 21);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
